gpio_ext_top: RTL

GPIO_EXT_TOP -- requirements
Module: gpio_ext_top

---
 rtl/gpio_ext_top.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gpio_ext_top.sv
// Wishbone GPIO block: pad sync, optional debounce, edge/level interrupts.
// Build option: define GPIO_DEBOUNCE_EN to add the debounce filter.
module gpio_ext_top #(
  parameter int N_PINS   = 32,
  parameter int DB_CNT_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [5:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [N_PINS-1:0] i_gpio,
  output logic [N_PINS-1:0] o_gpio,
  output logic [N_PINS-1:0] en_gpio,
  output logic              wb_inta_o
);
  localparam int N = N_PINS;

  logic          acc, start, wr;
  logic [3:0]    idx;
  logic [31:0]   bmask, rdata;
  logic [N-1:0]  wm, wd, wset, is_clr;
  logic [N-1:0]  out_q, oe_q, ie_q, is_q;
  logic [N-1:0]  imode_q, ipol_q, iany_q;
  logic [N-1:0]  sync0, sync1, filt, prev_q;
  logic [N-1:0]  edge_ev, lvl_ev, evt;
  logic          unused_ok;

  assign acc   = wb_cyc_i & wb_stb_i;
  assign start = acc & ~wb_ack_o;
  assign wr    = start & wb_we_i;
  assign idx   = wb_adr_i[5:2];
  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                  {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wm    = bmask[N-1:0];
  assign wd    = wb_dat_i[N-1:0];
  assign wset  = wd & wm;
  assign is_clr = (wr && idx == 4'd6) ? wset : '0;
  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i, bmask};

  assign edge_ev = (iany_q & (filt ^ prev_q))
                 | (~iany_q & ipol_q & filt & ~prev_q)
                 | (~iany_q & ~ipol_q & ~filt & prev_q);
  assign lvl_ev  = ~(filt ^ ipol_q);
  assign evt     = (imode_q & edge_ev) | (~imode_q & lvl_ev);

  assign o_gpio    = out_q;
  assign en_gpio   = oe_q;
  assign wb_err_o  = 1'b0;
  assign wb_inta_o = |(ie_q & is_q);

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] dbcfg_q, pres_q, db_m, db_d;
  logic [N-1:0]        filt_q;
  logic [1:0]          stab_q [N];
  logic                db_wr, tick, bypass;

  assign db_wr  = wr && idx == 4'd10;
  assign db_m   = bmask[DB_CNT_W-1:0];
  assign db_d   = wb_dat_i[DB_CNT_W-1:0];
  assign tick   = pres_q == dbcfg_q;
  assign bypass = dbcfg_q == '0;
  assign filt   = bypass ? sync1 : filt_q;

  // A pin's counter restarts whenever it agrees with filt again.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      dbcfg_q <= '0;
      pres_q  <= '0;
      filt_q  <= '0;
      for (int i = 0; i < N; i++) stab_q[i] <= '0;
    end else begin
      if (db_wr) begin
        dbcfg_q <= (dbcfg_q & ~db_m) | (db_d & db_m);
        pres_q  <= '0;
      end else if (tick) begin
        pres_q <= '0;
      end else begin
        pres_q <= pres_q + DB_CNT_W'(1);
      end
      for (int i = 0; i < N; i++) begin
        if (db_wr || sync1[i] == filt_q[i]) begin
          stab_q[i] <= '0;
        end else if (tick) begin
          if (stab_q[i] == 2'd2) filt_q[i] <= sync1[i];
          else stab_q[i] <= stab_q[i] + 2'd1;
        end
      end
      if (bypass) filt_q <= sync1;
    end
  end
`else
  assign filt = sync1;
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      4'd0:  rdata[N-1:0] = filt;
      4'd1,
      4'd3,
      4'd4:  rdata[N-1:0] = out_q;
      4'd2:  rdata[N-1:0] = oe_q;
      4'd5:  rdata[N-1:0] = ie_q;
      4'd6:  rdata[N-1:0] = is_q;
      4'd7:  rdata[N-1:0] = imode_q;
      4'd8:  rdata[N-1:0] = ipol_q;
      4'd9:  rdata[N-1:0] = iany_q;
`ifdef GPIO_DEBOUNCE_EN
      4'd10: rdata[DB_CNT_W-1:0] = dbcfg_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      sync0    <= '0;
      sync1    <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      ie_q     <= '0;
      is_q     <= '0;
      imode_q  <= '1;
      ipol_q   <= '1;
      iany_q   <= '0;
    end else begin
      wb_ack_o <= start;
      if (start) wb_dat_o <= rdata;
      sync0  <= i_gpio;
      sync1  <= sync0;
      prev_q <= filt;
      // A new event beats a same-cycle clear.
      is_q <= (is_q & ~is_clr) | (evt & ie_q);
      if (wr) begin
        case (idx)
          4'd1: out_q   <= (out_q & ~wm) | wset;
          4'd2: oe_q    <= (oe_q & ~wm) | wset;
          4'd3: out_q   <= out_q | wset;
          4'd4: out_q   <= out_q & ~wset;
          4'd5: ie_q    <= (ie_q & ~wm) | wset;
          4'd7: imode_q <= (imode_q & ~wm) | wset;
          4'd8: ipol_q  <= (ipol_q & ~wm) | wset;
          4'd9: iany_q  <= (iany_q & ~wm) | wset;
          default: ;
        endcase
      end
    end
  end
endmodule
